vga_timing_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 VGA sync generator.
- Generates h_sync/v_sync, display-enable and a scaled {v,h} pixel coordinate from the system clock.
- Uses an internal pixel-clock-enable divider, configurable porch/sync widths and sync polarities, and adds line/frame start strobes.
- Sits between the system clock domain and the framebuffer read port / VGA pins.

---
 rtl/vga_timing_gen.sv | 175 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. Divides the system clock into a
// pixel-rate tick, walks a horizontal/vertical raster, and presents
// registered sync, display-enable, scaled pixel coordinate and line/frame
// start strobes one clock after each counter update.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   en_i           run enable; low freezes divider, counters and outputs
//   pix_tick_o     one-clk strobe on every output register update
//   h_sync_o       horizontal sync, asserted level HSYNC_POL
//   v_sync_o       vertical sync, asserted level VSYNC_POL
//   in_disp_o      high while the presented pixel is in the active area
//   pixel_pos_o    {v_pix, h_pix}, counters >> SCALE_SHIFT, 0 while blanking
//   line_start_o   one-clk strobe when h=0 is presented
//   frame_start_o  one-clk strobe when h=0,v=0 is presented
//
// Build option:
//   VGA_PREFETCH_EN  when defined, pixel_pos_o carries the coordinate of the
//                    NEXT pixel (gated by that pixel's display-enable) to
//                    hide one pixel of framebuffer read latency.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV     = 2,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int HSYNC_POL   = 0,
    parameter int VSYNC_POL   = 0,
    parameter int SCALE_SHIFT = 2,
    parameter int POS_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    output logic               pix_tick_o,
    output logic               h_sync_o,
    output logic               v_sync_o,
    output logic               in_disp_o,
    output logic [2*POS_W-1:0] pixel_pos_o,
    output logic               line_start_o,
    output logic               frame_start_o
);

    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W        = $clog2(H_TOTAL);
    localparam int V_W        = $clog2(V_TOTAL);
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int H_SYNC_BEG = H_ACTIVE + H_FP;
    localparam int H_SYNC_END = H_ACTIVE + H_FP + H_SYNC;
    localparam int V_SYNC_BEG = V_ACTIVE + V_FP;
    localparam int V_SYNC_END = V_ACTIVE + V_FP + V_SYNC;
    localparam logic HS_ON    = 1'(HSYNC_POL);
    localparam logic VS_ON    = 1'(VSYNC_POL);

    logic [DIV_W-1:0] div_cnt;
    logic [H_W-1:0]   h_cnt;
    logic [V_W-1:0]   v_cnt;
    logic             div_last;
    logic             tick;
    logic             h_last;
    logic             v_last;

    assign div_last = (int'(div_cnt) == CLK_DIV - 1);
    assign tick     = en_i && div_last;
    assign h_last   = (int'(h_cnt) == H_TOTAL - 1);
    assign v_last   = (int'(v_cnt) == V_TOTAL - 1);

    // ---------------- divider ----------------
    // NOTE: sequential state is assigned with <= only, so every flop samples
    // pre-edge values regardless of the order the always blocks are evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (en_i) begin
            div_cnt <= div_last ? '0 : div_cnt + 1'b1;
        end
    end

    // ---------------- raster counters ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // ---------------- decode of the current counter position ----------------
    logic h_sync_act;
    logic v_sync_act;
    logic disp_now;

    assign h_sync_act = (int'(h_cnt) >= H_SYNC_BEG) && (int'(h_cnt) < H_SYNC_END);
    assign v_sync_act = (int'(v_cnt) >= V_SYNC_BEG) && (int'(v_cnt) < V_SYNC_END);
    assign disp_now   = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);

    // Coordinate source for pixel_pos_o: current pixel, or with prefetch the
    // pixel the counters will step to next (same wrap rules as the counters).
    logic [H_W-1:0] pos_h;
    logic [V_W-1:0] pos_v;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        pos_h = h_cnt;
        pos_v = v_cnt;
`ifdef VGA_PREFETCH_EN
        if (h_last) begin
            pos_h = '0;
            pos_v = v_last ? '0 : v_cnt + 1'b1;
        end else begin
            pos_h = h_cnt + 1'b1;
        end
`endif
    end

    logic               pos_disp;
    logic [2*POS_W-1:0] pos_next;

    assign pos_disp = (int'(pos_h) < H_ACTIVE) && (int'(pos_v) < V_ACTIVE);
    assign pos_next = pos_disp ? {POS_W'(pos_v >> SCALE_SHIFT), POS_W'(pos_h >> SCALE_SHIFT)}
                               : '0;

    // ---------------- output stage ----------------
    // upd_pend marks that the counters moved and must be presented on the
    // next enabled clock. It comes out of reset set, so the first enabled
    // clock presents (0,0) without waiting for a divider tick.
    logic upd_pend;
    logic upd;

    assign upd = en_i && upd_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_pend      <= 1'b1;
            pix_tick_o    <= 1'b0;
            h_sync_o      <= ~HS_ON;
            v_sync_o      <= ~VS_ON;
            in_disp_o     <= 1'b0;
            pixel_pos_o   <= '0;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
        end else begin
            if (en_i) begin
                upd_pend <= tick;
            end
            pix_tick_o    <= upd;
            line_start_o  <= upd && (h_cnt == '0);
            frame_start_o <= upd && (h_cnt == '0) && (v_cnt == '0);
            if (upd) begin
                h_sync_o    <= h_sync_act ? HS_ON : ~HS_ON;
                v_sync_o    <= v_sync_act ? VS_ON : ~VS_ON;
                in_disp_o   <= disp_now;
                pixel_pos_o <= pos_next;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Drives four differently configured vga_timing_gen instances from one clock,
// reset and enable. The reference model works from the number of enabled
// clocks since reset: pixel index = (enabled_clks-1)/CLK_DIV, raster position
// and all outputs follow from that index with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct packed {
        int d;
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        int hpol; int vpol;
        int sh; int pw;
    } cfg_t;

    localparam cfg_t C_SMALL = '{d:2, ha:8, hf:2, hs:3, hb:1, va:4, vf:1, vs:2, vb:1,
                                 hpol:0, vpol:0, sh:0, pw:8};
    localparam cfg_t C_POL   = '{d:2, ha:8, hf:2, hs:3, hb:1, va:4, vf:1, vs:2, vb:1,
                                 hpol:1, vpol:1, sh:0, pw:8};
    localparam cfg_t C_DIV1  = '{d:1, ha:8, hf:2, hs:3, hb:1, va:4, vf:1, vs:2, vb:1,
                                 hpol:0, vpol:0, sh:0, pw:2};
    localparam cfg_t C_WIDE  = '{d:1, ha:640, hf:16, hs:96, hb:48, va:8, vf:1, vs:2, vb:1,
                                 hpol:0, vpol:0, sh:2, pw:8};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en_i = 1'b0;

    always #5 clk = ~clk;

    logic [3:0]  tk, hs, vs, ds, ls, fs;
    logic [15:0] pos_s, pos_p, pos_w;
    logic [3:0]  pos_d;

    vga_timing_gen #(
        .CLK_DIV(C_SMALL.d), .H_ACTIVE(C_SMALL.ha), .H_FP(C_SMALL.hf), .H_SYNC(C_SMALL.hs),
        .H_BP(C_SMALL.hb), .V_ACTIVE(C_SMALL.va), .V_FP(C_SMALL.vf), .V_SYNC(C_SMALL.vs),
        .V_BP(C_SMALL.vb), .HSYNC_POL(C_SMALL.hpol), .VSYNC_POL(C_SMALL.vpol),
        .SCALE_SHIFT(C_SMALL.sh), .POS_W(C_SMALL.pw)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .pix_tick_o(tk[0]), .h_sync_o(hs[0]),
        .v_sync_o(vs[0]), .in_disp_o(ds[0]), .pixel_pos_o(pos_s), .line_start_o(ls[0]),
        .frame_start_o(fs[0])
    );

    vga_timing_gen #(
        .CLK_DIV(C_POL.d), .H_ACTIVE(C_POL.ha), .H_FP(C_POL.hf), .H_SYNC(C_POL.hs),
        .H_BP(C_POL.hb), .V_ACTIVE(C_POL.va), .V_FP(C_POL.vf), .V_SYNC(C_POL.vs),
        .V_BP(C_POL.vb), .HSYNC_POL(C_POL.hpol), .VSYNC_POL(C_POL.vpol),
        .SCALE_SHIFT(C_POL.sh), .POS_W(C_POL.pw)
    ) u_pol (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .pix_tick_o(tk[1]), .h_sync_o(hs[1]),
        .v_sync_o(vs[1]), .in_disp_o(ds[1]), .pixel_pos_o(pos_p), .line_start_o(ls[1]),
        .frame_start_o(fs[1])
    );

    vga_timing_gen #(
        .CLK_DIV(C_DIV1.d), .H_ACTIVE(C_DIV1.ha), .H_FP(C_DIV1.hf), .H_SYNC(C_DIV1.hs),
        .H_BP(C_DIV1.hb), .V_ACTIVE(C_DIV1.va), .V_FP(C_DIV1.vf), .V_SYNC(C_DIV1.vs),
        .V_BP(C_DIV1.vb), .HSYNC_POL(C_DIV1.hpol), .VSYNC_POL(C_DIV1.vpol),
        .SCALE_SHIFT(C_DIV1.sh), .POS_W(C_DIV1.pw)
    ) u_div1 (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .pix_tick_o(tk[2]), .h_sync_o(hs[2]),
        .v_sync_o(vs[2]), .in_disp_o(ds[2]), .pixel_pos_o(pos_d), .line_start_o(ls[2]),
        .frame_start_o(fs[2])
    );

    vga_timing_gen #(
        .CLK_DIV(C_WIDE.d), .H_ACTIVE(C_WIDE.ha), .H_FP(C_WIDE.hf), .H_SYNC(C_WIDE.hs),
        .H_BP(C_WIDE.hb), .V_ACTIVE(C_WIDE.va), .V_FP(C_WIDE.vf), .V_SYNC(C_WIDE.vs),
        .V_BP(C_WIDE.vb), .HSYNC_POL(C_WIDE.hpol), .VSYNC_POL(C_WIDE.vpol),
        .SCALE_SHIFT(C_WIDE.sh), .POS_W(C_WIDE.pw)
    ) u_wide (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .pix_tick_o(tk[3]), .h_sync_o(hs[3]),
        .v_sync_o(vs[3]), .in_disp_o(ds[3]), .pixel_pos_o(pos_w), .line_start_o(ls[3]),
        .frame_start_o(fs[3])
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int e_cnt    = 0;     // enabled clocks since reset release
    bit en_edge  = 1'b0;  // last posedge was an enabled, out-of-reset edge

    bit measure   = 1'b0;
    int last_fs   = -1;
    int last_ls   = -1;
    int disp_cnt  = 0;
    int exp_frame = 224;
    int exp_line  = 28;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected {pix_tick, h_sync, v_sync, in_disp, line_start, frame_start, pos[15:0]}.
    function automatic logic [21:0] model(input cfg_t c, input int e, input bit edge_en);
        int htot, vtot, p, q, h, v, qh, qv, mask;
        logic tk_e, hs_e, vs_e, disp, qdisp;
        logic [15:0] pos;
        if (e == 0) begin
            return {1'b0, ~c.hpol[0], ~c.vpol[0], 3'b000, 16'h0000};
        end
        htot = c.ha + c.hf + c.hs + c.hb;
        vtot = c.va + c.vf + c.vs + c.vb;
        p    = (e - 1) / c.d;
        h    = p % htot;
        v    = (p / htot) % vtot;
        tk_e = edge_en && ((e - 1) % c.d == 0);
        hs_e = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.hpol[0] : ~c.hpol[0];
        vs_e = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.vpol[0] : ~c.vpol[0];
        disp = (h < c.ha) && (v < c.va);
`ifdef VGA_PREFETCH_EN
        q = p + 1;
`else
        q = p;
`endif
        qh    = q % htot;
        qv    = (q / htot) % vtot;
        qdisp = (qh < c.ha) && (qv < c.va);
        mask  = (1 << c.pw) - 1;
        pos   = qdisp ? 16'((((qv >> c.sh) & mask) << c.pw) | ((qh >> c.sh) & mask)) : 16'h0000;
        return {tk_e, hs_e, vs_e, disp, tk_e && (h == 0), tk_e && (h == 0) && (v == 0), pos};
    endfunction

    function automatic logic [21:0] observed(input int k);
        case (k)
            0:       return {tk[0], hs[0], vs[0], ds[0], ls[0], fs[0], pos_s};
            1:       return {tk[1], hs[1], vs[1], ds[1], ls[1], fs[1], pos_p};
            2:       return {tk[2], hs[2], vs[2], ds[2], ls[2], fs[2], 12'h000, pos_d};
            default: return {tk[3], hs[3], vs[3], ds[3], ls[3], fs[3], pos_w};
        endcase
    endfunction

    function automatic cfg_t cfg_of(input int k);
        case (k)
            0:       return C_SMALL;
            1:       return C_POL;
            2:       return C_DIV1;
            default: return C_WIDE;
        endcase
    endfunction

    task automatic compare_all();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("dut%0d_outputs", k), 32'(observed(k)), 32'(model(cfg_of(k), e_cnt, en_edge)));
        end
    endtask

    // Period / pixel-count monitor on the small instance.
    task automatic monitor();
        if (!measure) return;
        if (fs[0]) begin
            if (last_fs >= 0) begin
                check("frame_period", cyc - last_fs, exp_frame);
                check("disp_pixels_per_frame", disp_cnt, 32);
            end
            last_fs   = cyc;
            disp_cnt  = 0;
            exp_frame = 224;
        end
        if (ls[0]) begin
            if (last_ls >= 0) check("line_period", cyc - last_ls, exp_line);
            last_ls  = cyc;
            exp_line = 28;
        end
        if (tk[0] && ds[0]) disp_cnt++;
    endtask

    // One clock: advance the model at the active edge, compare at the falling edge.
    task automatic step();
        @(posedge clk);
        en_edge = rst_n && en_i;
        if (!rst_n) e_cnt = 0;
        else if (en_i) e_cnt++;
        @(negedge clk);
        cyc++;
        compare_all();
        monitor();
    endtask

    // Asynchronous reset assertion between clock edges, checked before any edge.
    task automatic assert_reset();
        #2;
        rst_n   = 1'b0;
        e_cnt   = 0;
        en_edge = 1'b0;
        #1;
        compare_all();
    endtask

    initial begin
        int n;
        int p_small;

        // Reset held with clock running.
        en_i = 1'b1;
        repeat (3) step();

        // Free-running: periods, display pixel count, sync windows via model.
        rst_n   = 1'b1;
        measure = 1'b1;
        repeat (700) step();

        // en_i low for 10 clks while h=5 of the first line is presented.
        n = 0;
        do begin step(); n++; end while (!fs[0] && n < 300);
        check("wait_frame_start", fs[0], 1'b1);
        exp_frame = 234;
        exp_line  = 38;
        repeat (10) step();
        en_i = 1'b0;
        repeat (10) step();
        en_i = 1'b1;
        n = 0;
        do begin step(); n++; end while (!tk[0] && n < 20);
        check("resume_latency", n, 2);
        repeat (300) step();

        // Reset pulsed while (7,2) is presented on the small instance.
        measure = 1'b0;
        n = 0;
        do begin
            step();
            n++;
            p_small = (e_cnt >= 1) ? ((e_cnt - 1) / 2) % 112 : -1;
        end while (!(tk[0] && p_small == 35) && n < 400);
        check("reach_h7_v2", p_small, 35);
`ifdef VGA_PREFETCH_EN
        check("pos_at_h7_v2", pos_s, 16'h0000);
`else
        check("pos_at_h7_v2", pos_s, 16'h0207);
`endif
        assert_reset();
        repeat (3) step();
        rst_n = 1'b1;
        n = 0;
        do begin step(); n++; end while (!fs[0] && n < 20);
        check("frame_start_after_reset", n, 1);
`ifdef VGA_PREFETCH_EN
        check("pos_first_pixel", pos_s, 16'h0001);
`else
        check("pos_first_pixel", pos_s, 16'h0000);
`endif
        check("disp_first_pixel", ds[0], 1'b1);
        last_fs = -1;
        last_ls = -1;
        measure = 1'b1;
        repeat (500) step();
        measure = 1'b0;

        // Randomised enable with one random reset pulse.
        for (int i = 0; i < 6000; i++) begin
            en_i = ($urandom_range(0, 3) != 0);
            if (i == 2500 + int'($urandom_range(0, 1000)) % 1000 && rst_n) begin
                assert_reset();
                step();
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        // Long enabled run so the wide instance covers whole frames.
        en_i = 1'b1;
        repeat (12000) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
